// File: rtl/muu_split_pkg.sv
// muu_split_pkg: state encoding, request header layout, opcode and meta-word layout constants
package muu_split_pkg;
  typedef logic [2:0] state_t;
  localparam state_t IDLE = 3'd0, HDR2 = 3'd1, KEY = 3'd2, VALUE = 3'd3, DROP = 3'd4;
  localparam int OPC_LSB = 24, PEER_LSB = 16, LOAD_LSB = 32, KEYLEN_LSB = 48;
  localparam int OPC_W = 8, PEER_W = 8, LOAD_W = 16, KEYLEN_W = 8, HDR2_W = 48;
  localparam logic [OPC_W-1:0] OPC_GET = 8'h00, OPC_SET = 8'h01, OPC_DEL = 8'h02;
  localparam int META_FIXED_W = OPC_W + HDR2_W + PEER_W + KEYLEN_W + LOAD_W;
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return v == '1 ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/muu_split_out_reg.sv
// muu_split_out_reg: output holding register, cleared on valid&ready, a same-cycle load wins
module muu_split_out_reg #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         ready,
  input  logic [W-1:0] din,
  output logic         valid,
  output logic [W-1:0] dout
);
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      dout <= '0;
    end else if (load) begin
      valid <= 1'b1;
      dout <= din;
    end else if (ready) valid <= 1'b0;
  end
endmodule

// File: rtl/muu_request_split_gen.sv
// muu_request_split_gen: request header/key/value splitter; MUU_SPLIT_BACKPRESSURE_EN stalls busy headers instead of dropping
module muu_request_split_gen
  import muu_split_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int NET_META_WIDTH = 64,
  parameter int USER_BITS = 3,
  parameter int MAX_KEY_WORDS = 4
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [DATA_WIDTH+NET_META_WIDTH-1:0]         s_axis_tdata,
  input  logic                                         s_axis_tvalid,
  input  logic                                         s_axis_tlast,
  input  logic [USER_BITS-1:0]                         s_axis_tuserid,
  output logic                                         s_axis_tready,
  output logic [63:0]                                  key_data,
  output logic                                         key_valid,
  output logic                                         key_last,
  input  logic                                         key_ready,
  output logic [USER_BITS+NET_META_WIDTH+META_FIXED_W-1:0] meta_data,
  output logic                                         meta_valid,
  input  logic                                         meta_ready,
  output logic [DATA_WIDTH-1:0]                        value_data,
  output logic                                         value_valid,
  output logic                                         value_last,
  output logic [15:0]                                  value_length,
  input  logic                                         value_ready,
  input  logic                                         value_almost_full,
  output logic                                         err_pulse,
  output logic [31:0]                                  drop_count
);
  localparam int MW = USER_BITS + NET_META_WIDTH + META_FIXED_W;
  localparam logic [KEYLEN_W-1:0] MAX_KEY = KEYLEN_W'(MAX_KEY_WORDS);
  state_t state;
  logic [USER_BITS-1:0] userid;
  logic [OPC_W-1:0] opcode;
  logic [PEER_W-1:0] peerid;
  logic [KEYLEN_W-1:0] keylen, h_keylen;
  logic [LOAD_W-1:0] vallen, cnt, h_loadlen;
  logic [NET_META_WIDTH-1:0] net_meta;
  logic outready, ready_new, admissible, acc, last_cnt, end_pkt;
  logic [64:0] key_q;
  logic [DATA_WIDTH+16:0] val_q;
  assign h_keylen = s_axis_tdata[KEYLEN_LSB +: KEYLEN_W];
  assign h_loadlen = s_axis_tdata[LOAD_LSB +: LOAD_W];
  assign outready = meta_ready & key_ready & value_ready;
  assign ready_new = outready & ~value_almost_full;
  assign admissible = h_keylen <= MAX_KEY && h_loadlen >= LOAD_W'(h_keylen) && !s_axis_tlast;
`ifdef MUU_SPLIT_BACKPRESSURE_EN
  assign s_axis_tready = state == IDLE ? ready_new : state == DROP ? 1'b1 : outready;
`else
  assign s_axis_tready = state == IDLE || state == DROP ? 1'b1 : outready;
`endif
  assign acc = s_axis_tvalid & s_axis_tready;
  assign last_cnt = cnt == 16'd1;
  // end_pkt marks the beat the header says should carry tlast
  assign end_pkt = last_cnt & (state == VALUE | vallen == '0);
  muu_split_out_reg #(.W(65)) u_key (
    .clk(clk), .rst(rst), .ready(key_ready),
    .load(acc & (state == KEY | (state == HDR2 & keylen == '0 & vallen == '0))),
    .din(state == KEY ? {last_cnt | s_axis_tlast, s_axis_tdata[63:0]} : {1'b1, 64'd0}),
    .valid(key_valid), .dout(key_q)
  );
  muu_split_out_reg #(.W(MW)) u_meta (
    .clk(clk), .rst(rst), .ready(meta_ready), .load(acc & state == HDR2),
    .din({userid, opcode, s_axis_tdata[HDR2_W-1:0], peerid, keylen, vallen, net_meta}),
    .valid(meta_valid), .dout(meta_data)
  );
  muu_split_out_reg #(.W(DATA_WIDTH + 17)) u_val (
    .clk(clk), .rst(rst), .ready(value_ready), .load(acc & state == VALUE),
    .din({last_cnt | s_axis_tlast, vallen, s_axis_tdata[DATA_WIDTH-1:0]}),
    .valid(value_valid), .dout(val_q)
  );
  assign key_data = key_q[63:0];
  assign key_last = key_valid & key_q[64];
  assign value_data = val_q[DATA_WIDTH-1:0];
  assign value_length = val_q[DATA_WIDTH +: 16];
  assign value_last = value_valid & val_q[DATA_WIDTH+16];
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      err_pulse <= 1'b0;
      drop_count <= '0;
      cnt <= '0;
      userid <= '0;
      opcode <= '0;
      peerid <= '0;
      keylen <= '0;
      vallen <= '0;
      net_meta <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (acc)
        case (state)
          IDLE:
            if (admissible && ready_new) begin
              userid <= s_axis_tuserid;
              opcode <= s_axis_tdata[OPC_LSB +: OPC_W];
              peerid <= s_axis_tdata[PEER_LSB +: PEER_W];
              keylen <= h_keylen;
              vallen <= h_loadlen - LOAD_W'(h_keylen);
              net_meta <= s_axis_tdata[DATA_WIDTH +: NET_META_WIDTH];
              state <= HDR2;
            end else begin
              drop_count <= sat_inc(drop_count);
              state <= s_axis_tlast ? IDLE : DROP;
            end
          HDR2:
            if (keylen == '0 && vallen == '0) begin
              err_pulse <= ~s_axis_tlast;
              state <= s_axis_tlast ? IDLE : DROP;
            end else begin
              cnt <= keylen == '0 ? vallen : LOAD_W'(keylen);
              state <= keylen == '0 ? VALUE : KEY;
            end
          KEY, VALUE: begin
            cnt <= cnt - 16'd1;
            if (last_cnt && !end_pkt && !s_axis_tlast) begin
              cnt <= vallen;
              state <= VALUE;
            end else if (end_pkt || s_axis_tlast) begin
              err_pulse <= !(end_pkt && s_axis_tlast);
              state <= end_pkt && !s_axis_tlast ? DROP : IDLE;
            end
          end
          default: if (s_axis_tlast) state <= IDLE;
        endcase
    end
  end
endmodule

// File: tb/tb_muu_request_split_gen.sv
// tb_muu_request_split_gen: packet-level reference model with handshake-by-handshake output comparison
module tb_muu_request_split_gen;
  localparam int DW = 128, NM = 32, UB = 3, MK = 4, TW = DW + NM, MW = UB + NM + 88;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic [TW-1:0] s_axis_tdata;
  logic s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [UB-1:0] s_axis_tuserid;
  logic [63:0] key_data;
  logic key_valid, key_last, key_ready;
  logic [MW-1:0] meta_data;
  logic meta_valid, meta_ready;
  logic [DW-1:0] value_data;
  logic value_valid, value_last, value_ready, value_almost_full;
  logic [15:0] value_length;
  logic err_pulse;
  logic [31:0] drop_count;
  muu_request_split_gen #(.DATA_WIDTH(DW), .NET_META_WIDTH(NM), .USER_BITS(UB), .MAX_KEY_WORDS(MK)) dut (
    .clk(clk), .rst(rst), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuserid(s_axis_tuserid), .s_axis_tready(s_axis_tready),
    .key_data(key_data), .key_valid(key_valid), .key_last(key_last), .key_ready(key_ready),
    .meta_data(meta_data), .meta_valid(meta_valid), .meta_ready(meta_ready),
    .value_data(value_data), .value_valid(value_valid), .value_last(value_last),
    .value_length(value_length), .value_ready(value_ready), .value_almost_full(value_almost_full),
    .err_pulse(err_pulse), .drop_count(drop_count)
  );
  int checks = 0, errors = 0, exp_drops = 0, exp_errs = 0, obs_errs = 0;
  int lm_keys = 0, lm_vals = 0, lm_err = 0;
  logic [15:0] lm_vallen = '0;
  bit abort = 1'b0;
  logic [TW-1:0] pb[$];
  logic pl[$];
  logic [UB-1:0] pu[$];
  logic [MW-1:0] exp_meta[$];
  logic [64:0] exp_key[$];
  logic [DW+16:0] exp_val[$];

  task automatic chk(input string n, input logic [255:0] a, input logic [255:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic extra(input string n, input logic [255:0] a);
    checks++;
    errors++;
    $display("FAIL %s_unexpected: got %h expected nothing", n, a);
  endtask

  // header + HDR2 + m further beats, tlast on the last one; hdr_only sends a lone tlast header
  task automatic make_pkt(input int kl, input int ll, input int m, input bit hdr_only);
    logic [TW-1:0] d;
    int n;
    n = hdr_only ? 1 : m + 2;
    pb.delete(); pl.delete(); pu.delete();
    for (int b = 0; b < n; b++) begin
      for (int w = 0; w < TW; w += 32) d[w +: 32] = $urandom;
      if (b == 0) begin
        d[55:48] = 8'(kl);
        d[47:32] = 16'(ll);
      end
      pb.push_back(d);
      pl.push_back(b == n - 1);
      pu.push_back(UB'($urandom));
    end
  endtask

  task automatic model(input bit rfn);
    logic [TW-1:0] h, b1, bt;
    logic [7:0] kl;
    logic [15:0] ll, vl;
    int m;
    h = pb[0];
    kl = h[55:48];
    ll = h[47:32];
    vl = ll - 16'(kl);
    lm_keys = 0; lm_vals = 0; lm_err = 0; lm_vallen = vl;
    if (pl[0] || int'(kl) > MK || ll < 16'(kl) || !rfn) begin
      exp_drops++;
      return;
    end
    b1 = pb[1];
    m = pb.size() - 2;
    exp_meta.push_back({pu[0], h[31:24], b1[47:0], h[23:16], kl, vl, h[DW +: NM]});
    if (ll == 0) begin
      exp_key.push_back({1'b1, 64'd0});
      lm_keys = 1;
    end
    for (int i = 1; i <= m && i <= int'(ll); i++) begin
      bt = pb[i + 1];
      if (i <= int'(kl)) begin
        exp_key.push_back({(i == int'(kl) || i == m) ? 1'b1 : 1'b0, bt[63:0]});
        lm_keys++;
      end else begin
        exp_val.push_back({(i == int'(ll) || i == m) ? 1'b1 : 1'b0, vl, bt[DW-1:0]});
        lm_vals++;
      end
    end
    if (m != int'(ll)) begin
      exp_errs++;
      lm_err = 1;
    end
  endtask

  task automatic send(input bit rnd, input int af_cycles);
    int idx = 0, wait_c = 0, cyc = 0;
    while (idx < pb.size() && !abort) begin
      @(negedge clk);
      key_ready = !rnd || $urandom_range(0, 99) < 85;
      meta_ready = !rnd || $urandom_range(0, 99) < 85;
      value_ready = !rnd || $urandom_range(0, 99) < 85;
      value_almost_full = cyc < af_cycles;
      s_axis_tvalid = !rnd || $urandom_range(0, 99) < 80;
      s_axis_tdata = pb[idx];
      s_axis_tlast = pl[idx];
      s_axis_tuserid = pu[idx];
      #1;
`ifdef MUU_SPLIT_BACKPRESSURE_EN
      if (idx == 0 && value_almost_full && s_axis_tvalid) chk("bp_stall_tready", 256'(s_axis_tready), 256'(0));
`endif
      if (s_axis_tvalid && s_axis_tready) begin
        if (idx == 0) model(key_ready && meta_ready && value_ready && !value_almost_full);
        idx++;
        wait_c = 0;
      end else if (++wait_c > 1000) begin
        checks++;
        errors++;
        $display("FAIL beat_timeout: beat %0d of packet never accepted, expected acceptance within 1000 cycles", idx);
        abort = 1'b1;
      end
      cyc++;
    end
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    value_almost_full = 1'b0;
  endtask

  task automatic idle(input int n, input bit rnd);
    repeat (n) begin
      @(negedge clk);
      s_axis_tvalid = 1'b0;
      value_almost_full = 1'b0;
      key_ready = !rnd || $urandom_range(0, 99) < 85;
      meta_ready = !rnd || $urandom_range(0, 99) < 85;
      value_ready = !rnd || $urandom_range(0, 99) < 85;
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (err_pulse) obs_errs++;
      if (meta_valid && meta_ready) begin
        if (exp_meta.size() == 0) extra("meta", 256'(meta_data));
        else chk("meta_word", 256'(meta_data), 256'(exp_meta.pop_front()));
      end
      if (key_valid && key_ready) begin
        if (exp_key.size() == 0) extra("key", 256'({key_last, key_data}));
        else chk("key_beat", 256'({key_last, key_data}), 256'(exp_key.pop_front()));
      end
      if (value_valid && value_ready) begin
        if (exp_val.size() == 0) extra("value", 256'({value_last, value_length, value_data}));
        else chk("value_beat", 256'({value_last, value_length, value_data}), 256'(exp_val.pop_front()));
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL global_timeout: simulation did not finish, expected finish before 800000");
    $fatal(1);
  end

  initial begin
    int kl, vl, ll, m, r;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tdata = '0; s_axis_tuserid = '0;
    key_ready = 1'b1; meta_ready = 1'b1; value_ready = 1'b1; value_almost_full = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_flags", 256'({key_valid, key_last, meta_valid, value_valid, value_last, err_pulse}), 256'(0));
    chk("reset_drop_count", 256'(drop_count), 256'(0));
    chk("reset_key_data", 256'(key_data), 256'(0));
    chk("reset_meta_data", 256'(meta_data), 256'(0));
    chk("reset_value", 256'({value_length, value_data}), 256'(0));
    rst = 1'b0;
    @(negedge clk);
    #1 chk("idle_tready", 256'(s_axis_tready), 256'(1));
    make_pkt(1, 3, 3, 0); send(0, 0); idle(5, 0);
    chk("t1_model_vallen", 256'(lm_vallen), 256'(2));
    chk("t1_model_keys", 256'(lm_keys), 256'(1));
    chk("t1_model_vals", 256'(lm_vals), 256'(2));
    chk("t1_drop_count", 256'(drop_count), 256'(0));
    chk("t1_drained", 256'(exp_key.size() + exp_val.size() + exp_meta.size()), 256'(0));
    make_pkt(0, 0, 0, 0); send(0, 0); idle(5, 0);
    chk("t2_model_keys", 256'(lm_keys), 256'(1));
    chk("t2_model_vals", 256'(lm_vals), 256'(0));
    chk("t2_err_count", 256'(obs_errs), 256'(0));
    make_pkt(5, 5, 4, 0); send(0, 0); idle(5, 0);
    chk("t3_drop_count", 256'(drop_count), 256'(1));
    chk("t3_model_keys", 256'(lm_keys), 256'(0));
    make_pkt(1, 2, 2, 0); send(0, 0); idle(5, 0);
    chk("t3_next_model_vals", 256'(lm_vals), 256'(1));
    chk("t3_next_drop_count", 256'(drop_count), 256'(1));
    make_pkt(0, 4, 2, 0); send(0, 0); idle(5, 0);
    chk("t4_model_err", 256'(lm_err), 256'(1));
    chk("t4_model_vals", 256'(lm_vals), 256'(2));
    chk("t4_err_count", 256'(obs_errs), 256'(1));
    make_pkt(1, 2, 2, 0); send(0, 4); idle(5, 0);
`ifdef MUU_SPLIT_BACKPRESSURE_EN
    chk("t5_drop_count", 256'(drop_count), 256'(1));
`else
    chk("t5_drop_count", 256'(drop_count), 256'(2));
`endif
    for (int p = 0; p < 1000 && !abort; p++) begin
      kl = $urandom_range(0, 5);
      vl = $urandom_range(0, 4);
      ll = kl + vl;
      if (kl > 0 && $urandom_range(0, 9) == 0) ll = kl - 1;
      r = $urandom_range(0, 9);
      m = ll;
      if (r == 1 && ll >= 2) m = $urandom_range(1, ll - 1);
      if (r == 2) m = ll + $urandom_range(1, 2);
      make_pkt(kl, ll, m, r == 0);
      send(1, 0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3), 1);
    end
    idle(40, 0);
    chk("final_meta_left", 256'(exp_meta.size()), 256'(0));
    chk("final_key_left", 256'(exp_key.size()), 256'(0));
    chk("final_value_left", 256'(exp_val.size()), 256'(0));
    chk("final_drop_count", 256'(drop_count), 256'(exp_drops));
    chk("final_err_count", 256'(obs_errs), 256'(exp_errs));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/muu_request_split_gen.md
Name: muu_request_split_gen

Overview:
- Parametrised successor to the 512-bit MUU request splitter.
- Sits between the network-side request stream and the MUU key/meta/value pipelines.
- Parses a two-beat request header, emits one meta word, a multi-word key stream and a value stream.
- Adds header-declared multi-word keys, configurable datapath width, tlast/length-mismatch detection with resync, drop accounting, and optional stall-instead-of-drop.

Parameters:
- DATA_WIDTH, 512, payload width of input and value output; multiple of 64, ≥128.
- NET_META_WIDTH, 64, sideband network metadata carried above payload in s_axis_tdata.
- USER_BITS, 3, width of s_axis_tuserid.
- MAX_KEY_WORDS, 4, largest accepted key length in beats; range 1..255.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_axis_tdata  in  DATA_WIDTH+NET_META_WIDTH  request beat
- s_axis_tvalid  in  1;  s_axis_tlast  in  1;  s_axis_tuserid  in  USER_BITS
- s_axis_tready  out  1  (combinational)
- key_data  out  64;  key_valid  out  1;  key_last  out  1;  key_ready  in  1
- meta_data  out  USER_BITS+NET_META_WIDTH+88;  meta_valid  out  1;  meta_ready  in  1
- value_data  out  DATA_WIDTH;  value_valid  out  1;  value_last  out  1;  value_length  out  16
- value_ready  in  1;  value_almost_full  in  1
- err_pulse  out  1  one-cycle pulse on length/tlast mismatch
- drop_count  out  32  saturating count of dropped requests

Behaviour:
- Reset:
  - All valid/last outputs, err_pulse and drop_count are 0; data outputs are 0.
  - State is IDLE.
  - Reset mid-packet discards the remainder: the block enters IDLE and treats the next beat as a header.
- Handshakes:
  - Output registers clear valid (and last) on valid&ready.
  - outready = meta_ready & key_ready & value_ready.
  - s_axis_tready = 1 in IDLE and DROP; outready in HDR2/KEY/VALUE.
- Header beat 0, field layout:
  - opcode = [31:24], peerid = [23:16], loadlen = [47:32] (beats after HDR2), keylen = [55:48] (beats).
  - net_meta = tdata[DATA_WIDTH +: NET_META_WIDTH].
  - vallen = loadlen − keylen (16-bit).
- IDLE, on a valid beat:
  - Admissible: keylen ≤ MAX_KEY_WORDS, loadlen ≥ keylen, tlast=0.
  - Admissible and readyfornew (outready & ~value_almost_full): capture fields and userid → HDR2.
  - Otherwise: drop_count++ (saturate at 2^32−1); → DROP, or stay in IDLE if tlast=1.
- HDR2 (beat 1):
  - Emit meta_data = {userid, opcode, beat1[47:0], peerid, keylen, vallen, net_meta}, meta_valid=1.
  - keylen=0 and vallen=0: key_valid=1, key_last=1, key_data=0 → IDLE. tlast must be 1 here, else err_pulse and → DROP.
  - keylen=0 and vallen>0: → VALUE.
  - Otherwise: → KEY.
- KEY:
  - Each beat: key_data = tdata[63:0], key_valid=1; key counter decrements.
  - key_last=1 on the final key beat; then → VALUE if vallen>0, else → IDLE.
- VALUE:
  - Each beat: value_data = tdata[DATA_WIDTH-1:0], value_valid=1, value_length = vallen (held for the whole value).
  - value_last=1 on the final counted beat → IDLE.
- Mismatch, in KEY or VALUE:
  - Early tlast: force key_last or value_last on that beat, err_pulse=1 → IDLE.
  - Missing tlast on the final counted beat: emit the beat normally with last=1, err_pulse=1 → DROP.
- DROP: consume beats until tlast, then → IDLE; no outputs asserted.
- Simultaneous output clear and new load in one cycle: the load wins.
- Latency: one cycle from input handshake to output valid.

Optional Feature:
- MUU_SPLIT_BACKPRESSURE_EN defined: in IDLE, s_axis_tready = readyfornew. A busy admissible header stalls and is never dropped; only inadmissible headers are dropped.
- Undefined: busy headers are dropped and counted, as above.

Decomposition:
- Package muu_split_pkg:
  - state enum {IDLE, HDR2, KEY, VALUE, DROP}.
  - Header field offsets and widths, opcode constants.
  - Meta-word field layout localparams.
- Natural sub-module muu_split_out_reg: valid/last/data register with ready-clear and load-priority. Instantiate three times (key, meta, value).

Test Plan:
- Header keylen=1, loadlen=3, then 3 beats: meta vallen=2; 1 key beat with key_last; 2 value beats, second with value_last; value_length=2.
- keylen=0, loadlen=0, tlast on beat 1: single key beat, key_data=0, key_last=1, meta emitted; back in IDLE.
- keylen=5 with MAX_KEY_WORDS=4, 6-beat packet: no outputs, drop_count=1, next packet processed normally.
- loadlen=4 with tlast on the 2nd value beat: value_last on that beat, err_pulse=1, return to IDLE.
- value_almost_full=1 at header: drop_count+1 without the macro; with MUU_SPLIT_BACKPRESSURE_EN, tready=0 until clear, then the packet passes intact.
- Random key_ready/value_ready/meta_ready stalls over 1000 packets: outputs match the reference model beat-for-beat, no loss or duplication.
